// File: rtl/alu_uart_interface.sv
// Byte-stream front end for the ALU: gathers A, B, OP from uart_rx,
// waits out the ALU latency and hands one result byte to uart_tx.
module alu_uart_interface #(
  parameter int N_BITS  = 8,
  parameter int N_OP    = 6,
  parameter int ALU_LAT = 1,
  parameter int TIMEOUT = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_rx_done,
  output logic [N_BITS-1:0] o_A,
  output logic [N_BITS-1:0] o_B,
  output logic [N_OP-1:0]   o_OP,
  input  logic [N_BITS-1:0] i_alu_result,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_done,
  output logic              o_busy,
  output logic              o_op_err,
  output logic              o_overrun
);

  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LAT - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
  } state_t;

  state_t state, state_n;

  logic [LW-1:0]     lat_cnt, lat_cnt_n;
  logic [TW-1:0]     to_cnt, to_cnt_n;
  logic [N_BITS-1:0] a_n, b_n, tx_data_n;
  logic [N_OP-1:0]   op_n;
  logic              start_n, busy_n, err_n, ovr_n;
  logic              op_ok, lat_last, to_hit, busy_st;

  // Opcode bits above N_OP are deliberately discarded.
  logic unused_rx_hi;
  assign unused_rx_hi = ^i_rx_data[N_BITS-1:N_OP];

  function automatic logic legal(input logic [N_OP-1:0] op);
    case (op)
      N_OP'(32'h20), N_OP'(32'h22), N_OP'(32'h24),
      N_OP'(32'h25), N_OP'(32'h26), N_OP'(32'h03),
      N_OP'(32'h02), N_OP'(32'h27): legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
  endfunction

  assign op_ok    = legal(i_rx_data[N_OP-1:0]);
  assign lat_last = (lat_cnt == LAT_LAST);
  assign to_hit   = (TIMEOUT > 0) && (to_cnt == TO_LAST);
  assign busy_st  = (state == EXEC) || (state == SEND) ||
                    (state == WAIT_TX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= WAIT_A;
      lat_cnt    <= '0;
      to_cnt     <= '0;
      o_A        <= '0;
      o_B        <= '0;
      o_OP       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_op_err   <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_n;
      lat_cnt    <= lat_cnt_n;
      to_cnt     <= to_cnt_n;
      o_A        <= a_n;
      o_B        <= b_n;
      o_OP       <= op_n;
      o_tx_data  <= tx_data_n;
      o_tx_start <= start_n;
      o_busy     <= busy_n;
      o_op_err   <= err_n;
      o_overrun  <= ovr_n;
    end
  end

  // A byte arriving on the timeout cycle wins over the abort.
  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_A:  if (i_rx_done) state_n = WAIT_B;
      WAIT_B: begin
        if (i_rx_done)   state_n = WAIT_OP;
        else if (to_hit) state_n = WAIT_A;
      end
      WAIT_OP: begin
        if (i_rx_done)   state_n = op_ok ? EXEC : WAIT_A;
        else if (to_hit) state_n = WAIT_A;
      end
      EXEC:    if (lat_last) state_n = SEND;
      SEND:    state_n = WAIT_TX;
      WAIT_TX: if (i_tx_done) state_n = WAIT_A;
      default: state_n = WAIT_A;
    endcase
  end

  always_comb begin
    a_n       = o_A;
    b_n       = o_B;
    op_n      = o_OP;
    tx_data_n = o_tx_data;
    if (i_rx_done && state == WAIT_A)  a_n  = i_rx_data;
    if (i_rx_done && state == WAIT_B)  b_n  = i_rx_data;
    if (i_rx_done && state == WAIT_OP) op_n = i_rx_data[N_OP-1:0];
    if (state == EXEC && lat_last)     tx_data_n = i_alu_result;
    start_n   = (state_n == SEND);
    busy_n    = (state_n == EXEC) || (state_n == SEND) ||
                (state_n == WAIT_TX);
    err_n     = i_rx_done && (state == WAIT_OP) && !op_ok;
    ovr_n     = i_rx_done && busy_st;
    lat_cnt_n = (state == EXEC && !lat_last) ? lat_cnt + 1'b1 : '0;
    to_cnt_n  = '0;
    if (state_n == state && (state == WAIT_B || state == WAIT_OP))
      to_cnt_n = to_cnt + 1'b1;
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: vector table of frames, a result
// scoreboard fed at stimulus time, and hand sequences for corner cases.
module tb_alu_uart_interface;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [7:0] o_A, o_B, o_tx_data, i_alu_result;
  logic [5:0] o_OP;
  logic       o_tx_start, i_tx_done, o_busy, o_op_err, o_overrun;

  alu_uart_interface #(
    .N_BITS(8), .N_OP(6), .ALU_LAT(1), .TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_A(o_A), .o_B(o_B), .o_OP(o_OP),
    .i_alu_result(i_alu_result),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .i_tx_done(i_tx_done), .o_busy(o_busy),
    .o_op_err(o_op_err), .o_overrun(o_overrun)
  );

  always #5 clock = ~clock;

  // Behavioural ALU standing in for the real one.
  always_comb begin
    case (o_OP)
      6'h20:   i_alu_result = o_A + o_B;
      6'h22:   i_alu_result = o_A - o_B;
      6'h24:   i_alu_result = o_A & o_B;
      6'h25:   i_alu_result = o_A | o_B;
      6'h26:   i_alu_result = o_A ^ o_B;
      6'h27:   i_alu_result = ~(o_A | o_B);
      6'h02:   i_alu_result = o_A >> o_B;
      6'h03:   i_alu_result = 8'($signed(o_A) >>> o_B);
      default: i_alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] a, b, op, res;
    bit         ok;
  } vec_t;

  vec_t       tbl[12];
  logic [7:0] sb[$];
  int n_vec = 0, n_bad = 0, n_start = 0, n_err = 0, n_ovr = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (o_op_err)  n_err++;
    if (o_overrun) n_ovr++;
    if (o_tx_start) begin
      n_start++;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected: got start data %0h expected none",
                 o_tx_data);
      end else begin
        chk("sb_data", 64'(o_tx_data), 64'(sb.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    cyc();
    i_rx_done = 1'b0;
  endtask

  task automatic do_frame(input vec_t v, input int idle, input string tag);
    int s0, e0;
    send(v.a);
    repeat (idle) cyc();
    send(v.b);
    if (v.ok) sb.push_back(v.res);
    s0 = n_start;
    e0 = n_err;
    send(v.op);
    chk({tag, " operands"}, 64'({o_A, o_B, o_OP}),
        64'({v.a, v.b, v.op[5:0]}));
    if (v.ok) begin
      chk({tag, " exec"}, 64'({o_busy, o_tx_start}), 64'(2'b10));
      cyc();
      chk({tag, " send"}, 64'({o_tx_start, o_tx_data}),
          64'({1'b1, v.res}));
      cyc();
      chk({tag, " wait_tx"}, 64'({o_busy, o_tx_start}), 64'(2'b10));
      i_tx_done = 1'b1;
      cyc();
      i_tx_done = 1'b0;
      chk({tag, " idle"}, 64'(o_busy), 64'(0));
    end else begin
      chk({tag, " err"}, 64'({o_op_err, o_busy}), 64'(2'b10));
      repeat (4) cyc();
      chk({tag, " err_once"}, 64'(n_err - e0), 64'(1));
      chk({tag, " no_start"}, 64'(n_start - s0), 64'(0));
    end
    chk({tag, " start_count"}, 64'(n_start - s0), 64'(v.ok ? 1 : 0));
  endtask

  initial begin
    int s0, o0;
    tbl[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b1};
    tbl[1]  = '{8'h0F, 8'h01, 8'h3F, 8'h00, 1'b0};
    tbl[2]  = '{8'hF0, 8'h0F, 8'h27, 8'h00, 1'b1};
    tbl[3]  = '{8'h02, 8'h04, 8'h22, 8'hFE, 1'b1};
    tbl[4]  = '{8'h06, 8'h02, 8'h24, 8'h02, 1'b1};
    tbl[5]  = '{8'h0C, 8'h0A, 8'h25, 8'h0E, 1'b1};
    tbl[6]  = '{8'h0C, 8'h0A, 8'h26, 8'h06, 1'b1};
    tbl[7]  = '{8'h80, 8'h02, 8'h03, 8'hE0, 1'b1};
    tbl[8]  = '{8'h80, 8'h02, 8'h02, 8'h20, 1'b1};
    tbl[9]  = '{8'hFF, 8'h01, 8'h20, 8'h00, 1'b1};
    tbl[10] = '{8'h12, 8'h34, 8'hE0, 8'h46, 1'b1};
    tbl[11] = '{8'h01, 8'h02, 8'h01, 8'h00, 1'b0};

    reset = 1'b1;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    repeat (3) cyc();
    chk("reset_outs", 64'({o_A, o_B, o_OP, o_tx_data, o_tx_start,
        o_busy, o_op_err, o_overrun}), 64'(0));
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 12; i++) do_frame(tbl[i], 0, $sformatf("vec%0d", i));

    // Byte landing on the last tolerated idle cycle is still taken.
    do_frame('{8'h03, 8'h04, 8'h20, 8'h07, 1'b1}, 15, "to_edge");

    // One more idle cycle aborts; A is retained.
    send(8'h09);
    repeat (16) cyc();
    chk("to_keep_a", 64'(o_A), 64'(8'h09));
    do_frame('{8'h02, 8'h04, 8'h22, 8'hFE, 1'b1}, 0, "to_abort");

    // Overrun while waiting for uart_tx, also coincident with tx_done.
    send(8'h05);
    send(8'h03);
    sb.push_back(8'h08);
    send(8'h20);
    cyc();
    cyc();
    o0 = n_ovr;
    send(8'hAA);
    chk("ovr1", 64'({o_overrun, o_busy}), 64'(2'b11));
    cyc();
    chk("ovr1_end", 64'(o_overrun), 64'(0));
    i_rx_data = 8'hAA;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    cyc();
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    chk("ovr2", 64'({o_overrun, o_busy}), 64'(2'b10));
    chk("ovr_count", 64'(n_ovr - o0), 64'(2));
    do_frame('{8'h0C, 8'h0A, 8'h25, 8'h0E, 1'b1}, 0, "after_ovr");

    // Reset during EXEC kills the pending transmission.
    send(8'h11);
    send(8'h22);
    s0 = n_start;
    send(8'h20);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_exec_outs", 64'({o_A, o_B, o_OP, o_tx_data, o_tx_start,
        o_busy, o_op_err, o_overrun}), 64'(0));
    repeat (5) cyc();
    chk("rst_exec_nostart", 64'(n_start - s0), 64'(0));
    do_frame('{8'h06, 8'h02, 8'h24, 8'h02, 1'b1}, 0, "after_rst");

    repeat (3) cyc();
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
